fetch_queue: RTL and testbench

- Instruction fetch front end that sits directly upstream of the IF/ID pipeline register. It replaces the bare pc+imem path.
- Issues sequential fetch requests to a variable-latency instruction memory port and buffers returned {pc, instruction} pairs in a small FIFO.
- Presents the FIFO head to IF/ID, honouring the pipeline `stall` signal.
- Handles taken-branch/jump redirects by flushing the queue and discarding responses still in flight.

---
 rtl/fetch_queue.sv | 144 ++++++++++++++
 tb/tb_fetch_queue.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// fetch_queue: instruction fetch front end feeding the IF/ID register.
// Issues sequential requests to a variable-latency, in-order imem port.
// Returned {pc, instruction} pairs are buffered in a DEPTH-entry FIFO whose
// head drives IF/ID. A redirect flushes the FIFO and discards every response
// that is still in flight.
// Optional build macro FETCH_BYPASS_EN: when it is defined, a response that
// arrives at an empty, idle queue goes straight to if_* in the same cycle.
module fetch_queue #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 4,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic                     clk,
  input  logic                     reset,
  output logic                     imem_req_valid,
  input  logic                     imem_req_ready,
  output logic [31:0]              imem_req_addr,
  input  logic                     imem_resp_valid,
  input  logic [31:0]              imem_resp_data,
  input  logic                     redirect_valid,
  input  logic [31:0]              redirect_pc,
  input  logic                     stall,
  output logic                     if_valid,
  output logic [31:0]              if_pc,
  output logic [31:0]              if_instruction,
  output logic [$clog2(DEPTH):0]   queue_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  // Control state.
  logic          r_active;      // low for the first cycle after reset so no request issues during reset
  logic [31:0]   r_fetch_pc;
  logic [CW-1:0] r_outstanding;
  logic [CW-1:0] r_drop_cnt;
  logic [CW-1:0] r_count;
  logic [AW-1:0] r_rd_ptr;
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_tag_rd;
  logic [AW-1:0] r_tag_wr;
  logic [31:0]   r_last_pc;

  // Storage: the tag FIFO holds the pc of each request in flight; the queue
  // holds the returned pairs.
  logic [31:0]   r_tag    [DEPTH];
  logic [31:0]   r_q_pc   [DEPTH];
  logic [31:0]   r_q_inst [DEPTH];

  logic          w_credit;
  logic          w_req_fire;
  logic          w_resp_drop;
  logic          w_resp_keep;
  logic          w_bypass;
  logic          w_push;
  logic          w_pop;
  logic [31:0]   w_redirect_pc;

  // Credit covers both the buffered entries and the requests in flight, so a
  // response always has a free slot waiting for it.
  assign w_credit      = ({1'b0, r_count} + {1'b0, r_outstanding}) < (CW+1)'(DEPTH);
  assign imem_req_valid = r_active && w_credit && !redirect_valid;
  assign imem_req_addr  = r_fetch_pc;
  assign w_req_fire    = imem_req_valid && imem_req_ready;

  // A response arriving during a redirect belongs to the stale stream.
  assign w_resp_drop   = imem_resp_valid && ((r_drop_cnt != '0) || redirect_valid);
  assign w_resp_keep   = imem_resp_valid && !w_resp_drop;
  assign w_redirect_pc = redirect_pc & 32'hFFFF_FFFC;

`ifdef FETCH_BYPASS_EN
  assign w_bypass = w_resp_keep && (r_count == '0) && !stall;
`else
  assign w_bypass = 1'b0;
`endif

  assign w_push      = w_resp_keep && !w_bypass;
  assign w_pop       = (r_count != '0) && !stall;
  assign queue_count = r_count;

  // Select what IF/ID sees: the bypassed response, the queue head, or a bubble.
  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    if_valid       = 1'b0;
    if_pc          = r_last_pc;
    if_instruction = NOP_INST;
    if (w_bypass) begin
      if_valid       = 1'b1;
      if_pc          = r_tag[r_tag_rd];
      if_instruction = imem_resp_data;
    end else if (r_count != '0) begin
      if_valid       = 1'b1;
      if_pc          = r_q_pc[r_rd_ptr];
      if_instruction = r_q_inst[r_rd_ptr];
    end
  end

  // Fetch pointer, in-flight bookkeeping and queue occupancy; a redirect takes priority.
  always_ff @(posedge clk or negedge reset) begin
    // NOTE: state updates use non-blocking assignments so every register samples pre-edge values.
    if (!reset) begin
      r_active      <= 1'b0;
      r_fetch_pc    <= RESET_PC;
      r_outstanding <= '0;
      r_drop_cnt    <= '0;
      r_count       <= '0;
      r_rd_ptr      <= '0;
      r_wr_ptr      <= '0;
      r_tag_rd      <= '0;
      r_tag_wr      <= '0;
      r_last_pc     <= '0;
    end else begin
      r_active      <= 1'b1;
      r_last_pc     <= if_pc;
      r_outstanding <= r_outstanding + CW'(w_req_fire) - CW'(imem_resp_valid);
      if (w_req_fire)      r_tag_wr <= r_tag_wr + AW'(1);
      if (imem_resp_valid) r_tag_rd <= r_tag_rd + AW'(1);
      if (redirect_valid) begin
        r_fetch_pc <= w_redirect_pc;
        r_drop_cnt <= r_outstanding - CW'(imem_resp_valid);
        r_count    <= '0;
        r_rd_ptr   <= '0;
        r_wr_ptr   <= '0;
      end else begin
        if (w_req_fire)  r_fetch_pc <= r_fetch_pc + 32'd4;
        if (w_resp_drop) r_drop_cnt <= r_drop_cnt - CW'(1);
        if (w_push)      r_wr_ptr   <= r_wr_ptr + AW'(1);
        if (w_pop)       r_rd_ptr   <= r_rd_ptr + AW'(1);
        r_count <= r_count + CW'(w_push) - CW'(w_pop);
      end
    end
  end

  // Tag and queue payload writes.
  always_ff @(posedge clk) begin
    // NOTE: payload arrays carry no reset; occupancy and pointers alone decide what is valid.
    if (w_req_fire) r_tag[r_tag_wr] <= r_fetch_pc;
    if (w_push) begin
      r_q_pc[r_wr_ptr]   <= r_tag[r_tag_rd];
      r_q_inst[r_wr_ptr] <= imem_resp_data;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed testbench for fetch_queue (default parameters, DEPTH=4).
// A small in-order imem model with configurable latency answers requests;
// instruction data is a fixed function of the fetch address.
module tb_fetch_queue;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b1;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid = 1'b0;
  logic [31:0] imem_resp_data = '0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        stall = 1'b0;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_instruction;
  logic [2:0]  queue_count;

  int total = 0;
  int bad   = 0;

  // imem model state
  logic [31:0] mq_addr[$];
  int          mq_due[$];
  int          lat = 1;
  int          cyc = 0;
  int          n_acc = 0;

  localparam logic [31:0] NOP = 32'h0000_0013;

  fetch_queue dut (
    .clk            (clk),
    .reset          (reset),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_resp_valid(imem_resp_valid),
    .imem_resp_data (imem_resp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .stall          (stall),
    .if_valid       (if_valid),
    .if_pc          (if_pc),
    .if_instruction (if_instruction),
    .queue_count    (queue_count)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return a ^ 32'hC0DE_0001;
  endfunction

  // Record this cycle's handshakes, move to the next negedge and drive the
  // model's response for the new cycle.
  task automatic adv();
    if (imem_resp_valid) begin
      void'(mq_addr.pop_front());
      void'(mq_due.pop_front());
    end
    if (imem_req_valid && imem_req_ready) begin
      mq_addr.push_back(imem_req_addr);
      mq_due.push_back(cyc + lat);
      n_acc++;
    end
    @(negedge clk);
    cyc++;
    if (mq_addr.size() > 0 && mq_due[0] <= cyc) begin
      imem_resp_valid = 1'b1;
      imem_resp_data  = inst_of(mq_addr[0]);
    end else begin
      imem_resp_valid = 1'b0;
      imem_resp_data  = '0;
    end
    #1;
  endtask

  task automatic apply_reset();
    reset           = 1'b0;
    stall           = 1'b0;
    redirect_valid  = 1'b0;
    redirect_pc     = '0;
    imem_req_ready  = 1'b1;
    imem_resp_valid = 1'b0;
    imem_resp_data  = '0;
    mq_addr.delete();
    mq_due.delete();
    n_acc = 0;
    repeat (2) @(negedge clk);
    #1;
  endtask

  task automatic restart(input int l);
    lat = l;
    apply_reset();
    reset = 1'b1;
    cyc   = 0;
    #1;
  endtask

  // Advance until the model holds n requests in flight (bounded).
  task automatic wait_inflight(input int n, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (mq_addr.size() == n) begin
        ok = 1'b1;
        break;
      end
      adv();
    end
  endtask

  // Advance until the DUT presents a valid head (bounded).
  task automatic wait_valid(output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (if_valid) begin
        ok = 1'b1;
        break;
      end
      adv();
    end
  endtask

  task automatic test_reset();
    apply_reset();
    total++; if (imem_req_valid !== 1'b0) begin bad++; $display("FAIL reset_req_valid: got %b want 0", imem_req_valid); end
    total++; if (if_valid !== 1'b0) begin bad++; $display("FAIL reset_if_valid: got %b want 0", if_valid); end
    total++; if (if_pc !== 32'h0) begin bad++; $display("FAIL reset_if_pc: got %h want 0", if_pc); end
    total++; if (if_instruction !== NOP) begin bad++; $display("FAIL reset_if_inst: got %h want %h", if_instruction, NOP); end
    total++; if (queue_count !== 3'd0) begin bad++; $display("FAIL reset_count: got %0d want 0", queue_count); end
  endtask

  task automatic test_basic();
    logic [31:0] exp;
    int first, got;
    restart(1);
    exp = 32'h0; first = -1; got = 0;
    for (int c = 0; c < 20 && got < 8; c++) begin
      if (first < 0 && !if_valid) begin
        total++; if (if_instruction !== NOP) begin bad++; $display("FAIL basic_empty_inst: got %h want %h", if_instruction, NOP); end
      end else begin
        if (first < 0) first = c;
        total++;
        if (if_valid !== 1'b1) begin
          bad++; $display("FAIL basic_bubble: cycle %0d if_valid got %b want 1", c, if_valid);
        end else if (if_pc !== exp || if_instruction !== inst_of(exp)) begin
          bad++; $display("FAIL basic_seq: pc got %h want %h inst got %h want %h", if_pc, exp, if_instruction, inst_of(exp));
          exp = exp + 32'd4; got++;
        end else begin
          exp = exp + 32'd4; got++;
        end
      end
      adv();
    end
    total++; if (got != 8) begin bad++; $display("FAIL basic_count: got %0d want 8", got); end
  endtask

  task automatic test_stall();
    restart(1);
    stall = 1'b1;
    #1;
    repeat (12) adv();
    total++; if (queue_count !== 3'd4) begin bad++; $display("FAIL stall_count: got %0d want 4", queue_count); end
    total++; if (imem_req_valid !== 1'b0) begin bad++; $display("FAIL stall_req_valid: got %b want 0", imem_req_valid); end
    total++; if (if_valid !== 1'b1 || if_pc !== 32'h0) begin bad++; $display("FAIL stall_head: valid %b pc %h want 1 00000000", if_valid, if_pc); end
    stall = 1'b0;
    #1;
    for (int i = 0; i < 8; i++) begin
      total++;
      if (if_valid !== 1'b1 || if_pc !== 32'(4 * i) || if_instruction !== inst_of(32'(4 * i))) begin
        bad++; $display("FAIL stall_drain: step %0d valid %b pc %h want pc %h", i, if_valid, if_pc, 32'(4 * i));
      end
      adv();
    end
  endtask

  task automatic test_redirect();
    bit ok;
    restart(3);
    wait_inflight(3, ok);
    total++; if (!ok) begin bad++; $display("FAIL redir_setup: inflight %0d want 3", mq_addr.size()); end
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0103;
    #1;
    total++; if (imem_req_valid !== 1'b0) begin bad++; $display("FAIL redir_req_valid: got %b want 0", imem_req_valid); end
    adv();
    redirect_valid = 1'b0;
    #1;
    total++; if (queue_count !== 3'd0) begin bad++; $display("FAIL redir_flush: count %0d want 0", queue_count); end
    wait_valid(ok);
    total++;
    if (!ok || if_pc !== 32'h100 || if_instruction !== inst_of(32'h100)) begin
      bad++; $display("FAIL redir_first: ok %b pc %h want 00000100 inst %h", ok, if_pc, if_instruction);
    end
    adv();
    wait_valid(ok);
    total++; if (!ok || if_pc !== 32'h104) begin bad++; $display("FAIL redir_second: ok %b pc %h want 00000104", ok, if_pc); end
  endtask

  task automatic test_redirect_collide();
    bit ok;
    restart(2);
    repeat (8) adv();
    total++; if (imem_req_valid !== 1'b1 || if_valid !== 1'b1) begin bad++; $display("FAIL collide_steady: req %b if_valid %b want 1 1", imem_req_valid, if_valid); end
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0200;
    stall          = 1'b1;
    #1;
    total++; if (imem_req_valid !== 1'b0) begin bad++; $display("FAIL collide_req_valid: got %b want 0", imem_req_valid); end
    adv();
    redirect_valid = 1'b0;
    stall          = 1'b0;
    #1;
    total++; if (queue_count !== 3'd0 || if_valid !== 1'b0) begin bad++; $display("FAIL collide_flush: count %0d valid %b want 0 0", queue_count, if_valid); end
    total++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h200) begin bad++; $display("FAIL collide_refetch: req %b addr %h want 1 00000200", imem_req_valid, imem_req_addr); end
    wait_valid(ok);
    total++;
    if (!ok || if_pc !== 32'h200 || if_instruction !== inst_of(32'h200)) begin
      bad++; $display("FAIL collide_first: ok %b pc %h want 00000200", ok, if_pc);
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    restart(3);
    wait_inflight(3, ok);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0300;
    #1;
    adv();
    redirect_valid = 1'b0;
    #1;
    adv();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0400;
    #1;
    adv();
    redirect_valid = 1'b0;
    #1;
    wait_valid(ok);
    total++; if (!ok || if_pc !== 32'h400) begin bad++; $display("FAIL b2b_first: ok %b pc %h want 00000400", ok, if_pc); end
    adv();
    wait_valid(ok);
    total++; if (!ok || if_pc !== 32'h404) begin bad++; $display("FAIL b2b_second: ok %b pc %h want 00000404", ok, if_pc); end
  endtask

  task automatic test_ready_low();
    logic [31:0] exp;
    restart(1);
    exp = 32'h0;
    for (int c = 0; c < 30; c++) begin
      imem_req_ready = !(c >= 6 && c < 11);
      #1;
      if (imem_req_valid) begin
        total++; if (imem_req_addr !== 32'(n_acc * 4)) begin bad++; $display("FAIL ready_addr: got %h want %h", imem_req_addr, 32'(n_acc * 4)); end
      end
      if (c >= 6 && c < 11) begin
        total++; if (imem_req_valid !== 1'b1) begin bad++; $display("FAIL ready_hold_valid: got %b want 1", imem_req_valid); end
      end
      if (if_valid) begin
        total++;
        if (if_pc !== exp || if_instruction !== inst_of(exp)) begin
          bad++; $display("FAIL ready_seq: pc got %h want %h", if_pc, exp);
        end
        exp = exp + 32'd4;
      end
      adv();
    end
    imem_req_ready = 1'b1;
    total++; if (exp < 32'h30) begin bad++; $display("FAIL ready_progress: next pc %h want >= 00000030", exp); end
    // Fill the queue, then assert reset between clock edges.
    stall = 1'b1;
    #1;
    repeat (3) adv();
    reset = 1'b0;
    #1;
    total++; if (imem_req_valid !== 1'b0) begin bad++; $display("FAIL midrst_req_valid: got %b want 0", imem_req_valid); end
    total++; if (if_valid !== 1'b0) begin bad++; $display("FAIL midrst_if_valid: got %b want 0", if_valid); end
    total++; if (if_pc !== 32'h0) begin bad++; $display("FAIL midrst_if_pc: got %h want 0", if_pc); end
    total++; if (if_instruction !== NOP) begin bad++; $display("FAIL midrst_inst: got %h want %h", if_instruction, NOP); end
    total++; if (queue_count !== 3'd0) begin bad++; $display("FAIL midrst_count: got %0d want 0", queue_count); end
    stall = 1'b0;
  endtask

  task automatic test_latency();
    bit ok;
    restart(1);
    ok = 1'b0;
    for (int c = 0; c < 10; c++) begin
      if (imem_resp_valid) begin
        ok = 1'b1;
        break;
      end
      adv();
    end
    total++; if (!ok) begin bad++; $display("FAIL lat_resp_timeout: no response within 10 cycles"); end
`ifdef FETCH_BYPASS_EN
    total++;
    if (if_valid !== 1'b1 || if_pc !== 32'h0 || if_instruction !== inst_of(32'h0)) begin
      bad++; $display("FAIL lat_bypass: valid %b pc %h inst %h want 1 00000000 %h", if_valid, if_pc, if_instruction, inst_of(32'h0));
    end
    total++; if (queue_count !== 3'd0) begin bad++; $display("FAIL lat_bypass_count: got %0d want 0", queue_count); end
`else
    total++; if (if_valid !== 1'b0) begin bad++; $display("FAIL lat_same_cycle: valid %b want 0", if_valid); end
    adv();
    total++;
    if (if_valid !== 1'b1 || if_pc !== 32'h0 || if_instruction !== inst_of(32'h0)) begin
      bad++; $display("FAIL lat_next_cycle: valid %b pc %h inst %h want 1 00000000 %h", if_valid, if_pc, if_instruction, inst_of(32'h0));
    end
`endif
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_redirect();
    test_redirect_collide();
    test_back_to_back();
    test_ready_low();
    test_latency();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
